regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Writeback scheduler in front of the dual-write-port register file of the dual-issue core.
- Merges four writeback sources onto the file's two write ports:
  - two in-order pipeline lines, which are never stalled;
  - two long-latency sources, LSU load return and divider, each with a valid/ready handshake.
- Keeps a 32-entry busy scoreboard of registers awaiting long-latency results; issue logic stalls on it.
- Drives a registered write bus in the same packed layout the register file consumes.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NREG, 32, number of architectural registers (entry 0 hardwired zero)

Ports:
- wb_in_clk  in  1  clock
- wb_in_rstL  in  1  asynchronous active-low reset
- l1_we  in  1  line1 pipeline write enable
- l1_waddr  in  ADDR_W  line1 write address
- l1_wdata  in  DATA_W  line1 write data
- l2_we  in  1  line2 pipeline write enable; line2 is younger than line1
- l2_waddr  in  ADDR_W  line2 write address
- l2_wdata  in  DATA_W  line2 write data
- lsu_valid  in  1  load result valid
- lsu_waddr  in  ADDR_W  load destination
- lsu_wdata  in  DATA_W  load data
- lsu_ready  out  1  load result accepted this cycle
- div_valid  in  1  divider result valid
- div_waddr  in  ADDR_W  divider destination
- div_wdata  in  DATA_W  divider data
- div_ready  out  1  divider result accepted this cycle
- iss_valid  in  1  long-latency op issued this cycle
- iss_waddr  in  ADDR_W  its destination
- busy_o  out  NREG  scoreboard, bit i = register i pending
- write_obus  out  2*(1+ADDR_W+DATA_W)  {we2,waddr2,wdata2,we1,waddr1,wdata1}, registered

Behaviour:
- Reset (asynchronous, wb_in_rstL=0):
  - write_obus=0, busy_o=0, rr_ptr=LSU.
  - lsu_ready/div_ready are combinational and held 0 while reset is asserted.
  - Reset mid-handshake drops the in-flight results; the sources re-present them after reset.
- Pipeline request validity: a pipeline request is live iff we=1 and waddr!=0. Live pipeline requests always win and are never back-pressured.
- Port assignment per cycle:
  - Both lines live → line1→port1, line2→port2. No long source is granted.
  - One line live → it takes port1. Port2 is free for one long source.
  - No line live → port1 and port2 are free.
- Long-source grant (combinational):
  - Requests with waddr=0 get ready=1 immediately, consume no port and write nothing.
  - Two free ports: both lsu and div may be granted. LSU takes the lower free port, div the next.
  - One free port and both requesting: grant the source at rr_ptr. rr_ptr toggles only on such a contended grant.
  - One free port and one requester: grant it. rr_ptr is unchanged.
  - ready = grant. Handshake completes when valid&&ready. Sources hold valid/waddr/wdata stable until ready.
- Output latency: write_obus registers the assignment on the next wb_in_clk edge (1-cycle latency). Unused ports have we=0, waddr=0, wdata=0.
- Same-address pair on the two ports: allowed. The register file resolves it with port2 winning, which gives line2-younger semantics. The scheduler itself never reorders line1/line2.
- Scoreboard update at each edge:
  - Set bit iss_waddr when iss_valid and iss_waddr!=0.
  - Clear bit waddr for each completed long handshake.
  - Set and clear of the same bit in one cycle → set wins (new issue). Bit 0 always reads 0.
- Hazard contract with issue logic: issue does not send pipeline writes to a busy register (WAW). The scheduler does not check this.
- Outstanding long results are not cancelled by a flush. Busy bits clear only on writeback.

Optional Feature:
- Macro: REGFILE_WB_SCHED_PERF_EN.
- With the macro defined, add output stall_cnt (32 bits, reset 0). It increments once per cycle in which any long source has valid=1 and ready=0, and wraps on overflow.
- Without the macro, the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - ADDR_W, DATA_W, NREG;
  - the write-bus width macro (same as the register file write bus);
  - source encodings SRC_LSU=0, SRC_DIV=1.
- One natural sub-module, wb_rr_arb2: 2-requester round-robin arbiter with a free-slot count input (0/1/2), grant outputs and pointer register.

Test Plan:
- Reset mid-operation: assert wb_in_rstL=0 while lsu_valid=1 and busy_o=0x0000_0110 → busy_o=0, write_obus=0, lsu_ready=0 during reset; after release the first contended grant goes to LSU.
- Pipeline saturation: l1(we,r3,0x11), l2(we,r4,0x22), lsu_valid r5 → lsu_ready=0. Next cycle write_obus={1,4,0x22,1,3,0x11}. LSU is granted in the first cycle with no live pipeline write.
- One free port, contention: l1 live r6; lsu r7=0xAA and div r8=0xBB both valid for 3 cycles → grants LSU, DIV, then nothing pending; port2 carries r7 then r8.
- Two free ports: no pipeline writes; lsu r9 and div r10 valid → both ready same cycle; next cycle port1=r9, port2=r10.
- Scoreboard: iss r12 at cycle0 → busy_o[12]=1 at cycle1. Div completes r12 while iss_valid r12 again in the same cycle → busy_o[12] stays 1.
- Zero register: lsu_valid waddr=0 → lsu_ready=1, no port used, write_obus we1=we2=0. iss_waddr=0 → busy_o unchanged.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, write-bus layout and long-source encodings for the writeback scheduler.
package regfile_wb_sched_pkg;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int NREG    = 32;
    localparam int WPORT_W = 1 + ADDR_W + DATA_W;
    localparam int WBUS_W  = 2 * WPORT_W;

    localparam int SRC_LSU = 0;
    localparam int SRC_DIV = 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wport_t;
endpackage

// File: rtl/regfile_wb_sched_arb.sv
// wb_rr_arb2: two-requester round-robin arbiter gated by the number of free write ports.
module wb_rr_arb2
    import regfile_wb_sched_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic [1:0] req,
    input  logic [1:0] free_cnt,
    output logic [1:0] gnt
);
    logic ptr;
    logic contended;

    always_comb begin
        gnt       = 2'b00;
        contended = 1'b0;
        if (free_cnt >= 2'd2) begin
            gnt = req;
        end else if (free_cnt == 2'd1) begin
            if (&req) begin
                contended = 1'b1;
                gnt[ptr]  = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer only advances when both sources fought over a single port.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            ptr <= 1'(SRC_LSU);
        end else if (contended) begin
            ptr <= ~ptr;
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: merges two pipeline lines and two long-latency sources onto two write ports.
// Optional stall counter output enabled by REGFILE_WB_SCHED_PERF_EN.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
(
    input  logic              wb_in_clk,
    input  logic              wb_in_rstL,
    input  logic              l1_we,
    input  logic [ADDR_W-1:0] l1_waddr,
    input  logic [DATA_W-1:0] l1_wdata,
    input  logic              l2_we,
    input  logic [ADDR_W-1:0] l2_waddr,
    input  logic [DATA_W-1:0] l2_wdata,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_ready,
    input  logic              div_valid,
    input  logic [ADDR_W-1:0] div_waddr,
    input  logic [DATA_W-1:0] div_wdata,
    output logic              div_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    output logic [NREG-1:0]   busy_o,
    output logic [WBUS_W-1:0] write_obus
`ifdef REGFILE_WB_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    logic        l1_live, l2_live;
    logic        lsu_req, div_req, lsu_zero, div_zero;
    logic [1:0]  free_cnt, gnt;
    wport_t      p1, p2;
    logic [NREG-1:0] busy_nxt;

    assign l1_live  = l1_we && (l1_waddr != '0);
    assign l2_live  = l2_we && (l2_waddr != '0);
    assign lsu_req  = lsu_valid && (lsu_waddr != '0);
    assign div_req  = div_valid && (div_waddr != '0);
    assign lsu_zero = lsu_valid && (lsu_waddr == '0);
    assign div_zero = div_valid && (div_waddr == '0);
    assign free_cnt = 2'd2 - {1'b0, l1_live} - {1'b0, l2_live};

    wb_rr_arb2 u_arb (
        .clk_sys  (wb_in_clk),
        .rst_b    (wb_in_rstL),
        .req      ({div_req, lsu_req}),
        .free_cnt (free_cnt),
        .gnt      (gnt)
    );

    // Writes to r0 are acknowledged without consuming a port.
    assign lsu_ready = wb_in_rstL && (lsu_zero || gnt[SRC_LSU]);
    assign div_ready = wb_in_rstL && (div_zero || gnt[SRC_DIV]);

    always_comb begin
        p1 = '0;
        p2 = '0;
        if (l1_live && l2_live) begin
            p1 = '{1'b1, l1_waddr, l1_wdata};
            p2 = '{1'b1, l2_waddr, l2_wdata};
        end else if (l1_live) begin
            p1 = '{1'b1, l1_waddr, l1_wdata};
        end else if (l2_live) begin
            p1 = '{1'b1, l2_waddr, l2_wdata};
        end
        if (free_cnt >= 2'd2) begin
            if (gnt[SRC_LSU]) begin
                p1 = '{1'b1, lsu_waddr, lsu_wdata};
                if (gnt[SRC_DIV]) p2 = '{1'b1, div_waddr, div_wdata};
            end else if (gnt[SRC_DIV]) begin
                p1 = '{1'b1, div_waddr, div_wdata};
            end
        end else if (gnt[SRC_LSU]) begin
            p2 = '{1'b1, lsu_waddr, lsu_wdata};
        end else if (gnt[SRC_DIV]) begin
            p2 = '{1'b1, div_waddr, div_wdata};
        end
    end

    // Clears first so a same-cycle re-issue of the register keeps it busy.
    always_comb begin
        busy_nxt = busy_o;
        if (gnt[SRC_LSU]) busy_nxt[lsu_waddr] = 1'b0;
        if (gnt[SRC_DIV]) busy_nxt[div_waddr] = 1'b0;
        if (iss_valid && (iss_waddr != '0)) busy_nxt[iss_waddr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
        if (!wb_in_rstL) begin
            write_obus <= '0;
            busy_o     <= '0;
        end else begin
            write_obus <= {p2, p1};
            busy_o     <= busy_nxt;
        end
    end

`ifdef REGFILE_WB_SCHED_PERF_EN
    always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
        if (!wb_in_rstL) begin
            stall_cnt <= '0;
        end else if ((lsu_valid && !lsu_ready) || (div_valid && !div_ready)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: hand-computed write-bus, ready and scoreboard values.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    logic              wb_in_clk = 1'b0;
    logic              wb_in_rstL;
    logic              l1_we, l2_we, lsu_valid, div_valid, iss_valid;
    logic [ADDR_W-1:0] l1_waddr, l2_waddr, lsu_waddr, div_waddr, iss_waddr;
    logic [DATA_W-1:0] l1_wdata, l2_wdata, lsu_wdata, div_wdata;
    logic              lsu_ready, div_ready;
    logic [NREG-1:0]   busy_o;
    logic [WBUS_W-1:0] write_obus;
`ifdef REGFILE_WB_SCHED_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 wb_in_clk = ~wb_in_clk;

    regfile_wb_sched dut (
        .wb_in_clk  (wb_in_clk),
        .wb_in_rstL (wb_in_rstL),
        .l1_we      (l1_we),
        .l1_waddr   (l1_waddr),
        .l1_wdata   (l1_wdata),
        .l2_we      (l2_we),
        .l2_waddr   (l2_waddr),
        .l2_wdata   (l2_wdata),
        .lsu_valid  (lsu_valid),
        .lsu_waddr  (lsu_waddr),
        .lsu_wdata  (lsu_wdata),
        .lsu_ready  (lsu_ready),
        .div_valid  (div_valid),
        .div_waddr  (div_waddr),
        .div_wdata  (div_wdata),
        .div_ready  (div_ready),
        .iss_valid  (iss_valid),
        .iss_waddr  (iss_waddr),
        .busy_o     (busy_o),
        .write_obus (write_obus)
`ifdef REGFILE_WB_SCHED_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WBUS_W-1:0] bus(input logic w2, input logic [4:0] a2, input logic [31:0] d2,
                                              input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        return {w2, a2, d2, w1, a1, d1};
    endfunction

    task automatic tick();
        @(posedge wb_in_clk);
        #1;
    endtask

    task automatic idle();
        l1_we = 0; l1_waddr = 0; l1_wdata = 0;
        l2_we = 0; l2_waddr = 0; l2_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        div_valid = 0; div_waddr = 0; div_wdata = 0;
        iss_valid = 0; iss_waddr = 0;
    endtask

    task automatic set_l1(input logic [4:0] a, input logic [31:0] d);
        l1_we = 1; l1_waddr = a; l1_wdata = d;
    endtask
    task automatic set_l2(input logic [4:0] a, input logic [31:0] d);
        l2_we = 1; l2_waddr = a; l2_wdata = d;
    endtask
    task automatic set_lsu(input logic [4:0] a, input logic [31:0] d);
        lsu_valid = 1; lsu_waddr = a; lsu_wdata = d;
    endtask
    task automatic set_div(input logic [4:0] a, input logic [31:0] d);
        div_valid = 1; div_waddr = a; div_wdata = d;
    endtask

    initial begin
        idle();
        wb_in_rstL = 0;
        repeat (2) tick();
        chk_vec("rst_busy", busy_o, 0);
        chk_vec("rst_bus", write_obus, 0);
        wb_in_rstL = 1;

        // Contended grant before reset leaves the pointer at DIV.
        set_l1(5'd1, 32'h1); set_lsu(5'd2, 32'h2); set_div(5'd3, 32'h3);
        #1 chk_vec("pre_rr_rdy", {lsu_ready, div_ready}, 2'b10);
        tick();
        chk_vec("pre_rr_bus", write_obus, bus(1, 5'd2, 32'h2, 1, 5'd1, 32'h1));
        idle();
        iss_valid = 1; iss_waddr = 5'd4; tick();
        iss_waddr = 5'd8; tick();
        idle();
        chk_vec("busy_110", busy_o, 32'h0000_0110);

        // Reset mid-handshake.
        set_lsu(5'd7, 32'hAA);
        wb_in_rstL = 0;
        #1 chk_vec("rst_lsu_rdy", lsu_ready, 0);
        chk_vec("rst_mid_busy", busy_o, 0);
        chk_vec("rst_mid_bus", write_obus, 0);
        tick(); tick();
        wb_in_rstL = 1;

        // One free port, contention: LSU first after reset, then DIV.
        set_l1(5'd6, 32'h66); set_div(5'd8, 32'hBB);
        #1 chk_vec("cont1_rdy", {lsu_ready, div_ready}, 2'b10);
        tick();
        chk_vec("cont1_bus", write_obus, bus(1, 5'd7, 32'hAA, 1, 5'd6, 32'h66));
        lsu_valid = 0;
        #1 chk_vec("cont2_rdy", {lsu_ready, div_ready}, 2'b01);
        tick();
        chk_vec("cont2_bus", write_obus, bus(1, 5'd8, 32'hBB, 1, 5'd6, 32'h66));
        div_valid = 0;
        tick();
        chk_vec("cont3_bus", write_obus, bus(0, 0, 0, 1, 5'd6, 32'h66));

        // Pointer: DIV wins next contention, single grant holds pointer, LSU wins after.
        set_lsu(5'd9, 32'h99); set_div(5'd10, 32'h1010);
        #1 chk_vec("rr_toggle", {lsu_ready, div_ready}, 2'b01);
        tick();
        div_valid = 0;
        #1 chk_vec("rr_single", {lsu_ready, div_ready}, 2'b10);
        tick();
        set_lsu(5'd11, 32'hB1); set_div(5'd13, 32'hD1);
        #1 chk_vec("rr_hold", {lsu_ready, div_ready}, 2'b10);
        tick();
        lsu_valid = 0;
        tick();
        idle();

        // Pipeline saturation.
        set_l1(5'd3, 32'h11); set_l2(5'd4, 32'h22); set_lsu(5'd5, 32'h55);
        #1 chk_vec("sat_rdy", lsu_ready, 0);
        tick();
        chk_vec("sat_bus", write_obus, bus(1, 5'd4, 32'h22, 1, 5'd3, 32'h11));
        l1_we = 0; l2_we = 0;
        #1 chk_vec("sat_free_rdy", lsu_ready, 1);
        tick();
        chk_vec("sat_free_bus", write_obus, bus(0, 0, 0, 1, 5'd5, 32'h55));
        idle();

        // Two free ports.
        set_lsu(5'd9, 32'h99); set_div(5'd10, 32'hA0);
        #1 chk_vec("two_rdy", {lsu_ready, div_ready}, 2'b11);
        tick();
        chk_vec("two_bus", write_obus, bus(1, 5'd10, 32'hA0, 1, 5'd9, 32'h99));
        idle();

        // Line1 write to r0 is not live.
        set_l1(5'd0, 32'hDEAD); set_lsu(5'd5, 32'h5); set_div(5'd6, 32'h6);
        #1 chk_vec("l1r0_rdy", {lsu_ready, div_ready}, 2'b11);
        tick();
        chk_vec("l1r0_bus", write_obus, bus(1, 5'd6, 32'h6, 1, 5'd5, 32'h5));
        idle();

        // Line2 alone takes port1, divider gets port2.
        set_l2(5'd14, 32'hE); set_div(5'd15, 32'hF);
        #1 chk_vec("l2only_rdy", {lsu_ready, div_ready}, 2'b01);
        tick();
        chk_vec("l2only_bus", write_obus, bus(1, 5'd15, 32'hF, 1, 5'd14, 32'hE));
        idle();

        // Scoreboard set / same-cycle set+clear / clear.
        iss_valid = 1; iss_waddr = 5'd12;
        tick();
        chk_vec("sb_set", busy_o, 32'h0000_1000);
        set_div(5'd12, 32'hC);
        #1 chk_vec("sb_div_rdy", div_ready, 1);
        tick();
        chk_vec("sb_set_wins", busy_o, 32'h0000_1000);
        iss_valid = 0;
        tick();
        chk_vec("sb_clear", busy_o, 0);
        idle();

        // Zero register handling.
        iss_valid = 1; iss_waddr = 5'd20;
        tick();
        chk_vec("sb_r20", busy_o, 32'h0010_0000);
        iss_waddr = 5'd0; set_lsu(5'd0, 32'h77);
        #1 chk_vec("zero_rdy", lsu_ready, 1);
        tick();
        chk_vec("iss_zero", busy_o, 32'h0010_0000);
        chk_vec("zero_bus", write_obus, 0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
